// File: rtl/pipe_pkg.sv
// Shared pipeline types for the execute back end: slot layout and the forwarding hit test.
package pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 4;
  localparam logic [REG_AW-1:0] REG_PC = 4'd15;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              load;
    logic              cpsrw;
    logic [3:0]        flags;
    logic [DATA_W-1:0] data;
  } pipe_slot_t;

  // PC reads always come from the register file, never from a pipeline slot.
  function automatic logic fwd_hit(pipe_slot_t s, logic [REG_AW-1:0] addr);
    return s.valid & s.wen & (s.rd == addr) & (addr != REG_PC);
  endfunction

endpackage

// File: rtl/exec_writeback_forward_if.sv
// Execute/writeback bus: execute results in, forwarded operands and write ports out.
interface exec_writeback_forward_if;
  import pipe_pkg::*;

  logic              exValidIN;
  logic [REG_AW-1:0] exRdIN;
  logic [DATA_W-1:0] exResultIN;
  logic              exWriteBackIN;
  logic              exLoadIN;
  logic              exCPSRwriteIN;
  logic [3:0]        exFlagsIN;
  logic              flushIN;
  logic [DATA_W-1:0] memDataIN;
  logic [REG_AW-1:0] rnAddrIN;
  logic [REG_AW-1:0] rmAddrIN;
  logic [DATA_W-1:0] rnDataRfIN;
  logic [DATA_W-1:0] rmDataRfIN;
  logic [DATA_W-1:0] rnDataOUT;
  logic [DATA_W-1:0] rmDataOUT;
  logic              stallOUT;
  logic              rfWriteEnOUT;
  logic [REG_AW-1:0] rfWriteAddrOUT;
  logic [DATA_W-1:0] rfWriteDataOUT;
  logic              cpsrWriteEnOUT;
  logic [3:0]        cpsrFlagsOUT;

  modport master (
    output exValidIN, exRdIN, exResultIN, exWriteBackIN, exLoadIN, exCPSRwriteIN, exFlagsIN,
           flushIN, memDataIN, rnAddrIN, rmAddrIN, rnDataRfIN, rmDataRfIN,
    input  rnDataOUT, rmDataOUT, stallOUT, rfWriteEnOUT, rfWriteAddrOUT, rfWriteDataOUT,
           cpsrWriteEnOUT, cpsrFlagsOUT
  );

  modport slave (
    input  exValidIN, exRdIN, exResultIN, exWriteBackIN, exLoadIN, exCPSRwriteIN, exFlagsIN,
           flushIN, memDataIN, rnAddrIN, rmAddrIN, rnDataRfIN, rmDataRfIN,
    output rnDataOUT, rmDataOUT, stallOUT, rfWriteEnOUT, rfWriteAddrOUT, rfWriteDataOUT,
           cpsrWriteEnOUT, cpsrFlagsOUT
  );

endinterface

// File: rtl/operand_forward_mux.sv
// Per-operand bypass: picks the youngest in-flight value for addr, else register-file data.
module operand_forward_mux
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  pipe_slot_t        mem_slot_i,
  input  pipe_slot_t        wb_slot_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = rf_data_i;
    // A load in MEM has no data yet; the stall covers that case.
    if (fwd_hit(mem_slot_i, addr_i) && !mem_slot_i.load) begin
      data_o = mem_slot_i.data;
    end else if (fwd_hit(wb_slot_i, addr_i)) begin
      data_o = wb_slot_i.data;
    end
  end

endmodule

// File: rtl/exec_writeback_forward.sv
// Execute back end: MEM/WB slots, register-file and CPSR write ports, operand forwarding
// and load-use stall.
module exec_writeback_forward
  import pipe_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  exec_writeback_forward_if.slave  bus
);

  pipe_slot_t mem_q, mem_d;
  pipe_slot_t wb_q, wb_d;

  always_comb begin
    mem_d       = '0;
    mem_d.valid = bus.exValidIN & ~bus.flushIN;
    mem_d.rd    = bus.exRdIN;
    mem_d.wen   = bus.exWriteBackIN;
    mem_d.load  = bus.exLoadIN;
    mem_d.cpsrw = bus.exCPSRwriteIN;
    mem_d.flags = bus.exFlagsIN;
    mem_d.data  = bus.exResultIN;

    wb_d      = mem_q;
    wb_d.data = mem_q.load ? bus.memDataIN : mem_q.data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  operand_forward_mux u_fwd_rn (
    .addr_i     (bus.rnAddrIN),
    .rf_data_i  (bus.rnDataRfIN),
    .mem_slot_i (mem_q),
    .wb_slot_i  (wb_q),
    .data_o     (bus.rnDataOUT)
  );

  operand_forward_mux u_fwd_rm (
    .addr_i     (bus.rmAddrIN),
    .rf_data_i  (bus.rmDataRfIN),
    .mem_slot_i (mem_q),
    .wb_slot_i  (wb_q),
    .data_o     (bus.rmDataOUT)
  );

  assign bus.stallOUT = mem_q.load &
                        (fwd_hit(mem_q, bus.rnAddrIN) | fwd_hit(mem_q, bus.rmAddrIN));

  assign bus.rfWriteEnOUT   = wb_q.valid & wb_q.wen;
  assign bus.rfWriteAddrOUT = wb_q.rd;
  assign bus.rfWriteDataOUT = wb_q.data;
  assign bus.cpsrWriteEnOUT = wb_q.valid & wb_q.cpsrw;
  assign bus.cpsrFlagsOUT   = wb_q.flags;

endmodule

// File: tb/tb_exec_writeback_forward.sv
// Scoreboard bench for exec_writeback_forward: directed vectors, queued expectations,
// negedge monitor.
module tb_exec_writeback_forward;
  import pipe_pkg::*;

  localparam int KRn = 0, KRm = 1, KStall = 2, KWen = 3, KWaddr = 4, KWdata = 5,
                 KCen = 6, KCflags = 7;

  typedef struct { int cyc; int kind; logic [31:0] val; } comb_exp_t;
  typedef struct { int cyc; logic [3:0] addr; logic [31:0] data; } wr_exp_t;
  typedef struct { int cyc; logic [3:0] flags; } cpsr_exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  comb_exp_t cq[$];
  wr_exp_t   wq[$];
  cpsr_exp_t fq[$];

  exec_writeback_forward_if bus ();

  exec_writeback_forward dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int kind);
    case (kind)
      KRn:     return bus.rnDataOUT;
      KRm:     return bus.rmDataOUT;
      KStall:  return {31'd0, bus.stallOUT};
      KWen:    return {31'd0, bus.rfWriteEnOUT};
      KWaddr:  return {28'd0, bus.rfWriteAddrOUT};
      KWdata:  return bus.rfWriteDataOUT;
      KCen:    return {31'd0, bus.cpsrWriteEnOUT};
      default: return {28'd0, bus.cpsrFlagsOUT};
    endcase
  endfunction

  function automatic string kname(int kind);
    case (kind)
      KRn:     return "rnData";
      KRm:     return "rmData";
      KStall:  return "stall";
      KWen:    return "rfWriteEn";
      KWaddr:  return "rfWriteAddr";
      KWdata:  return "rfWriteData";
      KCen:    return "cpsrWriteEn";
      default: return "cpsrFlags";
    endcase
  endfunction

  // Monitor: combinational expectations by cycle, writes whenever the DUT presents one.
  always @(negedge clk) begin : monitor
    comb_exp_t   ce;
    wr_exp_t     we;
    cpsr_exp_t   fe;
    logic [31:0] act;
    while (cq.size() > 0 && cq[0].cyc <= cyc) begin
      ce  = cq.pop_front();
      act = actual(ce.kind);
      checks++;
      if (ce.cyc != cyc || act !== ce.val) begin
        failures++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", kname(ce.kind), cyc, act, ce.val);
      end
    end
    if (bus.rfWriteEnOUT === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL rfWrite unexpected cyc=%0d addr=%0d data=%h", cyc,
                 bus.rfWriteAddrOUT, bus.rfWriteDataOUT);
      end else begin
        we = wq.pop_front();
        if (we.cyc != cyc || bus.rfWriteAddrOUT !== we.addr || bus.rfWriteDataOUT !== we.data) begin
          failures++;
          $display("FAIL rfWrite cyc=%0d actual=%0d/%h required cyc=%0d %0d/%h", cyc,
                   bus.rfWriteAddrOUT, bus.rfWriteDataOUT, we.cyc, we.addr, we.data);
        end
      end
    end
    if (bus.cpsrWriteEnOUT === 1'b1) begin
      checks++;
      if (fq.size() == 0) begin
        failures++;
        $display("FAIL cpsrWrite unexpected cyc=%0d flags=%b", cyc, bus.cpsrFlagsOUT);
      end else begin
        fe = fq.pop_front();
        if (fe.cyc != cyc || bus.cpsrFlagsOUT !== fe.flags) begin
          failures++;
          $display("FAIL cpsrWrite cyc=%0d actual=%b required cyc=%0d %b", cyc,
                   bus.cpsrFlagsOUT, fe.cyc, fe.flags);
        end
      end
    end
  end

  task automatic exp_c(int kind, logic [31:0] val);
    comb_exp_t e;
    e.cyc = cyc; e.kind = kind; e.val = val;
    cq.push_back(e);
  endtask

  task automatic exp_w(logic [3:0] addr, logic [31:0] data);
    wr_exp_t e;
    e.cyc = cyc + 2; e.addr = addr; e.data = data;
    wq.push_back(e);
  endtask

  task automatic exp_f(logic [3:0] flags);
    cpsr_exp_t e;
    e.cyc = cyc + 2; e.flags = flags;
    fq.push_back(e);
  endtask

  task automatic idle();
    bus.exValidIN     = 1'b0;
    bus.exRdIN        = '0;
    bus.exResultIN    = '0;
    bus.exWriteBackIN = 1'b0;
    bus.exLoadIN      = 1'b0;
    bus.exCPSRwriteIN = 1'b0;
    bus.exFlagsIN     = '0;
    bus.flushIN       = 1'b0;
    bus.memDataIN     = '0;
    bus.rnAddrIN      = 4'd0;
    bus.rmAddrIN      = 4'd1;
    bus.rnDataRfIN    = 32'hF000_0000;
    bus.rmDataRfIN    = 32'hF000_0001;
  endtask

  task automatic ex(logic [3:0] rd, logic [31:0] res, logic wen, logic ld, logic cw,
                    logic [3:0] fl, logic fls);
    bus.exValidIN     = 1'b1;
    bus.exRdIN        = rd;
    bus.exResultIN    = res;
    bus.exWriteBackIN = wen;
    bus.exLoadIN      = ld;
    bus.exCPSRwriteIN = cw;
    bus.exFlagsIN     = fl;
    bus.flushIN       = fls;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0;
    reset = 1'b0;
    idle();
    step();

    // Reset held low with random stimulus, including load hazards.
    for (int i = 0; i < 4; i++) begin
      bus.exValidIN     = 1'($urandom);
      bus.exRdIN        = 4'($urandom);
      bus.exResultIN    = $urandom;
      bus.exWriteBackIN = 1'b1;
      bus.exLoadIN      = 1'($urandom);
      bus.exCPSRwriteIN = 1'b1;
      bus.exFlagsIN     = 4'($urandom);
      bus.rnAddrIN      = bus.exRdIN;
      bus.rmAddrIN      = 4'($urandom);
      bus.rnDataRfIN    = $urandom;
      bus.rmDataRfIN    = $urandom;
      bus.memDataIN     = $urandom;
      exp_c(KRn, bus.rnDataRfIN);
      exp_c(KRm, bus.rmDataRfIN);
      exp_c(KStall, 0);
      exp_c(KWen, 0);
      exp_c(KWaddr, 0);
      exp_c(KWdata, 0);
      exp_c(KCen, 0);
      exp_c(KCflags, 0);
      step();
    end
    idle();
    reset = 1'b1;
    step();

    // Mid-stream reset drops a pending write to r3.
    ex(4'd3, 32'h33, 1'b1, 1'b0, 1'b1, 4'b0101, 1'b0);
    step();
    idle();
    bus.rnAddrIN = 4'd3;
    bus.rnDataRfIN = 32'h1000;
    #1 reset = 1'b0;
    exp_c(KRn, 32'h1000);
    exp_c(KWen, 0);
    step();
    reset = 1'b1;
    bus.rnAddrIN = 4'd3;
    bus.rnDataRfIN = 32'h1000;
    exp_c(KRn, 32'h1000);
    step();
    step();

    // ALU back-to-back forwarding: MEM, then WB, then register file.
    ex(4'd2, 32'h11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    exp_w(4'd2, 32'h11);
    step();
    idle();
    bus.rnAddrIN = 4'd2; bus.rnDataRfIN = 32'hFFFF;
    exp_c(KRn, 32'h11);
    step();
    bus.rnAddrIN = 4'd2; bus.rnDataRfIN = 32'hFFFF;
    exp_c(KRn, 32'h11);
    step();
    bus.rnAddrIN = 4'd2; bus.rnDataRfIN = 32'hFFFF;
    exp_c(KRn, 32'hFFFF);
    step();

    // Double match on r5: MEM beats WB.
    ex(4'd5, 32'hA, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    exp_w(4'd5, 32'hA);
    step();
    ex(4'd5, 32'hB, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    bus.rmAddrIN = 4'd5;
    exp_w(4'd5, 32'hB);
    exp_c(KRm, 32'hA);
    step();
    idle();
    bus.rmAddrIN = 4'd5;
    exp_c(KRm, 32'hB);
    step();
    bus.rmAddrIN = 4'd5;
    exp_c(KRm, 32'hB);
    step();
    idle();

    // Load-use on r4: one stall cycle, then the loaded value forwards from WB.
    ex(4'd4, 32'h400, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    bus.rnAddrIN = 4'd4;
    exp_c(KStall, 0);
    exp_w(4'd4, 32'hDEAD);
    step();
    idle();
    bus.rnAddrIN = 4'd4; bus.memDataIN = 32'hDEAD;
    exp_c(KStall, 1);
    step();
    idle();
    bus.rnAddrIN = 4'd4;
    exp_c(KStall, 0);
    exp_c(KRn, 32'hDEAD);
    exp_c(KRm, 32'hF000_0001);
    step();

    // Flush squashes r7 but not the older r6 already in MEM.
    ex(4'd6, 32'h66, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    exp_w(4'd6, 32'h66);
    step();
    ex(4'd7, 32'h77, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    bus.rmAddrIN = 4'd6;
    exp_c(KRm, 32'h66);
    step();
    idle();
    bus.rnAddrIN = 4'd7; bus.rmAddrIN = 4'd6;
    exp_c(KRn, 32'hF000_0000);
    exp_c(KRm, 32'h66);
    step();
    bus.rnAddrIN = 4'd7;
    exp_c(KRn, 32'hF000_0000);
    step();

    // PC destination with flags: no forward, no stall, write and CPSR still issued.
    ex(4'd15, 32'h1234, 1'b1, 1'b0, 1'b1, 4'b1010, 1'b0);
    exp_w(4'd15, 32'h1234);
    exp_f(4'b1010);
    step();
    idle();
    bus.rnAddrIN = 4'd15; bus.rnDataRfIN = 32'hABC;
    exp_c(KRn, 32'hABC);
    exp_c(KStall, 0);
    step();
    bus.rnAddrIN = 4'd15; bus.rnDataRfIN = 32'hABC;
    exp_c(KRn, 32'hABC);
    exp_c(KCflags, 32'b1010);
    step();
    idle();

    // Load into r15 never stalls.
    ex(4'd15, 32'h800, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    exp_w(4'd15, 32'h5555);
    step();
    idle();
    bus.rnAddrIN = 4'd15; bus.rmAddrIN = 4'd15; bus.memDataIN = 32'h5555;
    exp_c(KStall, 0);
    exp_c(KRn, 32'hF000_0000);
    step();
    idle();
    for (int i = 0; i < 3; i++) step();

    checks++;
    if (wq.size() != 0 || fq.size() != 0 || cq.size() != 0) begin
      failures++;
      $display("FAIL drain pending_writes=%0d pending_cpsr=%0d pending_comb=%0d required=0",
               wq.size(), fq.size(), cq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
